stream_flow_controller: RTL

STREAM_FLOW_CONTROLLER -- requirements
Module: stream_flow_controller

---
 rtl/stream_flow_if.sv | 10 +
 rtl/stream_flow_controller.sv | 93 +++++++++
 2 files changed

// File: rtl/stream_flow_if.sv
// stream_flow_if: FIFO-side handshake between the stream flow controller and the sample FIFO
interface stream_flow_if #(parameter int LEVEL_W = 5);
  logic frame_req;
  logic [LEVEL_W-1:0] fifo_level;
  logic write_en;
  logic read_en;
  logic fifo_flush;
  modport master (input frame_req, fifo_level, output write_en, read_en, fifo_flush);
  modport slave (output frame_req, fifo_level, input write_en, read_en, fifo_flush);
endinterface

// File: rtl/stream_flow_controller.sv
// stream_flow_controller: sequences lock, frame sync, FIFO priming and playback with under/overrun recovery
module stream_flow_controller #(
  parameter int DEPTH = 16,
  parameter int LEVEL_W = 5,
  parameter int PRIME_LEVEL = 8,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_lock,
  input  logic fclk_in,
  stream_flow_if.master bus,
  output logic mute,
  output logic [2:0] state,
  output logic [7:0] underrun_cnt,
  output logic [7:0] overrun_cnt,
  output logic led_r,
  output logic led_g,
  output logic led_b
);
  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, SYNC = 3'd1, PRIME = 3'd2, RUN = 3'd3, RECOVER = 3'd4} state_t;
  state_t cur, nxt;
  logic [1:0] lock_sync;
  logic [2:0] fclk_sync;
  logic [CNT_W-1:0] lock_cnt;
  logic lock, fedge, full, empty, ovr, unr, fe_seen, wr, rd, flush;
  assign lock = lock_sync[1];
  assign fedge = fclk_sync[1] & ~fclk_sync[2];
  assign full = bus.fifo_level == LEVEL_W'(DEPTH);
  assign empty = bus.fifo_level == '0;
  // lock loss outranks boundary events, so they are gated by lock
  assign ovr = lock & fedge & full & (cur == PRIME || cur == RUN);
  assign unr = lock & bus.frame_req & empty & (cur == RUN);
  always_comb begin
    nxt = cur;
    wr = 1'b0;
    rd = 1'b0;
    flush = 1'b0;
    if (cur != IDLE && !lock) begin
      nxt = IDLE;
      flush = cur != RECOVER;
    end else begin
      case (cur)
        IDLE: nxt = (lock && lock_cnt == CNT_W'(LOCK_CYCLES - 1)) ? SYNC : IDLE;
        SYNC: nxt = (fedge && fe_seen) ? PRIME : SYNC;
        PRIME: begin
          wr = fedge & ~full;
          nxt = ovr ? RECOVER : (bus.fifo_level >= LEVEL_W'(PRIME_LEVEL)) ? RUN : PRIME;
        end
        RUN: begin
          wr = fedge & ~full & ~unr;
          rd = bus.frame_req & ~empty & ~ovr;
          nxt = (ovr || unr) ? RECOVER : RUN;
        end
        RECOVER: nxt = SYNC;
        default: nxt = IDLE;
      endcase
      flush = nxt == RECOVER;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= IDLE;
      lock_sync <= '0;
      fclk_sync <= '0;
      lock_cnt <= '0;
      fe_seen <= 1'b0;
      mute <= 1'b1;
      bus.write_en <= 1'b0;
      bus.read_en <= 1'b0;
      bus.fifo_flush <= 1'b0;
      underrun_cnt <= '0;
      overrun_cnt <= '0;
    end else begin
      cur <= nxt;
      lock_sync <= {lock_sync[0], pll_lock};
      fclk_sync <= {fclk_sync[1:0], fclk_in};
      lock_cnt <= (cur == IDLE && lock && nxt == IDLE) ? lock_cnt + 1'b1 : '0;
      fe_seen <= cur == SYNC && nxt == SYNC && (fe_seen || fedge);
      mute <= nxt != RUN;
      bus.write_en <= wr;
      bus.read_en <= rd;
      bus.fifo_flush <= flush;
      if (unr && underrun_cnt != 8'hff) underrun_cnt <= underrun_cnt + 8'd1;
      if (ovr && overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
  assign state = cur;
  assign led_r = ~(cur == IDLE || cur == RECOVER);
  assign led_g = ~(cur == RUN);
  assign led_b = ~(cur == SYNC || cur == PRIME || cur == RECOVER);
endmodule
